// File: rtl/fetch_queue.sv
// Mask-compacting instruction queue between fetch and decode: sparse fetch lanes
// are packed into contiguous entries, and up to ISSUE_WIDTH entries are presented per cycle.
module fetch_queue #(
  parameter int DATA_WIDTH  = 96,
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int DEPTH       = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 flush_i,
  input  logic                                 hold_i,
  input  logic                                 write_valid_i,
  input  logic [FETCH_WIDTH-1:0]               write_mask_i,
  input  logic [FETCH_WIDTH*DATA_WIDTH-1:0]    write_data_i,
  output logic                                 write_ready_o,
  output logic [ISSUE_WIDTH-1:0]               read_valid_o,
  output logic [ISSUE_WIDTH*DATA_WIDTH-1:0]    read_data_o,
  input  logic                                 read_ready_i,
  input  logic [$clog2(ISSUE_WIDTH+1)-1:0]     read_num_i,
  output logic [$clog2(DEPTH+1)-1:0]           count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FILL_LIMIT = CNT_W'(DEPTH - FETCH_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      n_mask;
  logic [CNT_W-1:0]      n_write;
  logic [CNT_W-1:0]      n_pop;
  logic [CNT_W-1:0]      num_ext;
  logic [PTR_W-1:0]      off_acc;
  logic [PTR_W-1:0]      lane_off [FETCH_WIDTH];
  logic                  accept;
  logic                  pop;

  // Ready looks only at the registered count; reads never grant same-cycle credit.
  assign write_ready_o = ~hold_i & (count <= FILL_LIMIT);
  assign accept        = write_valid_i & write_ready_o & ~flush_i;
  assign pop           = read_ready_i & ~flush_i;
  assign num_ext       = CNT_W'(read_num_i);
  assign n_pop         = pop ? ((num_ext < count) ? num_ext : count) : '0;
  assign n_write       = accept ? n_mask : '0;
  assign count_o       = count;

  // Each active lane lands at tail plus the number of active lanes below it.
  always_comb begin
    n_mask  = '0;
    off_acc = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      lane_off[k] = off_acc;
      if (write_mask_i[k]) begin
        off_acc = off_acc + PTR_W'(1);
        n_mask  = n_mask + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
        if (write_mask_i[k])
          mem[tail + lane_off[k]] <= write_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    read_valid_o = '0;
    read_data_o  = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      read_valid_o[k]                          = (count > CNT_W'(k));
      read_data_o[k*DATA_WIDTH +: DATA_WIDTH]  = mem[head + PTR_W'(k)];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + n_pop[PTR_W-1:0];
      tail  <= tail + n_write[PTR_W-1:0];
      count <= count + n_write - n_pop;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic, checked against
// a queue-based reference model of the fetch/issue rules.
module tb_fetch_queue;

  localparam int DW    = 96;
  localparam int FW    = 2;
  localparam int IW    = 2;
  localparam int DEPTH = 8;

  logic           clk;
  logic           rst_n;
  logic           flush_i;
  logic           hold_i;
  logic           write_valid_i;
  logic [FW-1:0]  write_mask_i;
  logic [FW*DW-1:0] write_data_i;
  logic           write_ready_o;
  logic [IW-1:0]  read_valid_o;
  logic [IW*DW-1:0] read_data_o;
  logic           read_ready_i;
  logic [1:0]     read_num_i;
  logic [3:0]     count_o;

  int total;
  int bad;
  logic [DW-1:0] model_q [$];

  fetch_queue #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW), .ISSUE_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .hold_i(hold_i),
    .write_valid_i(write_valid_i), .write_mask_i(write_mask_i), .write_data_i(write_data_i),
    .write_ready_o(write_ready_o), .read_valid_o(read_valid_o), .read_data_o(read_data_o),
    .read_ready_i(read_ready_i), .read_num_i(read_num_i), .count_o(count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare every visible output against the model's view of the queue.
  task automatic checkState();
    checkOutput("count", 128'(count_o), 128'(model_q.size()));
    checkOutput("write_ready", 128'(write_ready_o),
                128'(!hold_i && (DEPTH - model_q.size() >= FW)));
    for (int k = 0; k < IW; k++) begin
      checkOutput($sformatf("valid%0d", k), 128'(read_valid_o[k]), 128'(k < model_q.size()));
      if (k < model_q.size())
        checkOutput($sformatf("data%0d", k), 128'(read_data_o[k*DW +: DW]), 128'(model_q[k]));
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check.
  task automatic applyStimulus(input logic fl, input logic hd, input logic wv,
                               input logic [1:0] m, input logic [DW-1:0] d0,
                               input logic [DW-1:0] d1, input logic rr, input logic [1:0] rn);
    logic          can_write;
    int            npop;
    logic [DW-1:0] lanes [2];
    flush_i       = fl;
    hold_i        = hd;
    write_valid_i = wv;
    write_mask_i  = m;
    write_data_i  = {d1, d0};
    read_ready_i  = rr;
    read_num_i    = rn;
    lanes[0] = d0;
    lanes[1] = d1;
    can_write = !hd && (DEPTH - model_q.size() >= FW);
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      npop = rr ? ((int'(rn) < model_q.size()) ? int'(rn) : model_q.size()) : 0;
      for (int i = 0; i < npop; i++) void'(model_q.pop_front());
      if (wv && can_write)
        for (int k = 0; k < FW; k++) if (m[k]) model_q.push_back(lanes[k]);
    end
    #1;
    checkState();
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, '0, '0, 1'b0, 2'd0);
  endtask

  task automatic flushCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, '0, '0, 1'b0, 2'd0);
  endtask

  logic [DW-1:0] va, vb, vc, vd, ve, vf, vx, vy;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    flush_i = 1'b0; hold_i = 1'b0; write_valid_i = 1'b0; write_mask_i = '0;
    write_data_i = '0; read_ready_i = 1'b0; read_num_i = '0;
    va = 96'hA; vb = 96'hB; vc = 96'hC; vd = 96'hD; ve = 96'hE; vf = 96'hF;
    vx = 96'hAAAA_0000_1111; vy = 96'hBBBB_0000_2222;

    #12;
    checkOutput("reset_count", 128'(count_o), 128'd0);
    checkOutput("reset_valid", 128'(read_valid_o), 128'd0);
    checkOutput("reset_ready", 128'(write_ready_o), 128'd1);
    hold_i = 1'b1;
    #1;
    checkOutput("reset_ready_hold", 128'(write_ready_o), 128'd0);
    hold_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Compaction of a sparse mask
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b10, 96'h5A5A, va, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b11, vb, vc, 1'b0, 2'd0);
    checkOutput("compact_count", 128'(count_o), 128'd3);
    checkOutput("compact_lane0", 128'(read_data_o[0 +: DW]), 128'(va));
    checkOutput("compact_lane1", 128'(read_data_o[DW +: DW]), 128'(vb));
    checkOutput("compact_valid", 128'(read_valid_o), 128'b11);

    // Fill and backpressure
    flushCycle();
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, 2'b11, 96'(100 + 2*i), 96'(101 + 2*i), 1'b0, 2'd0);
    checkOutput("fill_count", 128'(count_o), 128'd8);
    checkOutput("fill_ready", 128'(write_ready_o), 128'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b11, 96'h77, 96'h78, 1'b1, 2'd2);
    checkOutput("fill_pop_count", 128'(count_o), 128'd6);
    checkOutput("fill_ready_after", 128'(write_ready_o), 128'd1);

    // Wrap-around with head = tail = 7
    flushCycle();
    for (int i = 0; i < 7; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, 2'b01, 96'(200 + i), '0, 1'b0, 2'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, '0, '0, 1'b1, 2'd2);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, '0, '0, 1'b1, 2'd1);
    checkOutput("wrap_empty", 128'(count_o), 128'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b11, vx, vy, 1'b0, 2'd0);
    checkOutput("wrap_lane0", 128'(read_data_o[0 +: DW]), 128'(vx));
    checkOutput("wrap_lane1", 128'(read_data_o[DW +: DW]), 128'(vy));
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, '0, '0, 1'b1, 2'd2);
    checkOutput("wrap_drained", 128'(count_o), 128'd0);

    // Simultaneous read and write
    flushCycle();
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b11, va, vb, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b01, vc, '0, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b11, vd, ve, 1'b1, 2'd2);
    checkOutput("simul_count", 128'(count_o), 128'd3);
    checkOutput("simul_lane0", 128'(read_data_o[0 +: DW]), 128'(vc));
    checkOutput("simul_lane1", 128'(read_data_o[DW +: DW]), 128'(vd));

    // Flush beats a same-cycle write and pop
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b11, 96'h31, 96'h32, 1'b0, 2'd0);
    checkOutput("flush_pre_count", 128'(count_o), 128'd5);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b11, 96'h41, 96'h42, 1'b1, 2'd2);
    checkOutput("flush_count", 128'(count_o), 128'd0);
    checkOutput("flush_valid", 128'(read_valid_o), 128'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b01, vf, '0, 1'b0, 2'd0);
    checkOutput("flush_then_f", 128'(read_data_o[0 +: DW]), 128'(vf));

    // Hold blocks writes but not reads
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b11, 96'h51, 96'h52, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b01, 96'h53, '0, 1'b0, 2'd0);
    checkOutput("hold_count", 128'(count_o), 128'd3);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b00, '0, '0, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b01, 96'h54, '0, 1'b0, 2'd0);
    hold_i = 1'b1;
    #1;
    checkOutput("hold_ready", 128'(write_ready_o), 128'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b11, 96'h61, 96'h62, 1'b1, 2'd2);
    checkOutput("hold_drain", 128'(count_o), 128'd2);

    // Asynchronous reset mid-operation, between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_count", 128'(count_o), 128'd0);
    checkOutput("async_valid", 128'(read_valid_o), 128'd0);
    model_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idleCycle();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) == 0),
                    1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom},
                    ($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised, mask-compacting instruction queue between I-cache fetch output and the decode stage of the frontend. Replaces fixed 2-in/2-out instruction FIFOs. Generalises to any fetch width, issue width and depth. Packs sparse fetch-lane masks (e.g. a fetch starting at an odd word) into contiguous entries, and adds an idle-hold input that blocks fills while still allowing drains.

## Interface
- DATA_WIDTH, 96: bits per entry (instruction word, PC, prediction, fetch exception, packed by the caller).
- FETCH_WIDTH, 2: write lanes per cycle; ≥1.
- ISSUE_WIDTH, 2: read lanes per cycle; ≥1.
- DEPTH, 8: entries; power of two, ≥ FETCH_WIDTH + ISSUE_WIDTH.
- clk  in  1  clock, single domain, all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- flush_i  in  1  discard all contents.
- hold_i  in  1  idle lock; forces write_ready_o low.
- write_valid_i  in  1  fetch group offered.
- write_mask_i  in  FETCH_WIDTH  per-lane valid; need not be contiguous.
- write_data_i  in  FETCH_WIDTH*DATA_WIDTH  lane k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- write_ready_o  out  1  queue can take a full FETCH_WIDTH group.
- read_valid_o  out  ISSUE_WIDTH  thermometer; bit k set when entry head+k exists.
- read_data_o  out  ISSUE_WIDTH*DATA_WIDTH  entries head..head+ISSUE_WIDTH-1.
- read_ready_i  in  1  consumer accepts this cycle (low = backend stall).
- read_num_i  in  $clog2(ISSUE_WIDTH+1)  entries consumed when read_ready_i.
- count_o  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- State: storage array DEPTH×DATA_WIDTH; head and tail pointers, $clog2(DEPTH) bits, wrap modulo DEPTH; count register.
- Write accept = write_valid_i & write_ready_o & ~flush_i.
- write_ready_o = ~hold_i & (DEPTH − count ≥ FETCH_WIDTH). Computed from registered count only; no same-cycle credit from reads.
- On accept, n = popcount(write_mask_i) entries are appended at tail..tail+n−1. Order is ascending lane index with masked-off lanes squeezed out. tail += n.
- Mask of all zeros with write_valid_i high is a legal no-op accept: nothing written.
- Read pop = read_ready_i & ~flush_i. Removes min(read_num_i, count) entries; head advances by the same amount.
- read_num_i above the number of valid lanes is clamped to count, never underflows. Checkers flag it as a protocol error.
- count_next = count + n_written − n_popped. Both may happen in the same cycle.
- read_data_o lanes with read_valid_o low carry don't-care data; bench must not check them.
- Flush has top priority. Next cycle head = tail = count = 0. Same-cycle write and pop are ignored.
- hold_i does not block reads. The queue drains normally while held.
- No write-to-read bypass: an entry written in cycle t is first visible on read_data_o in cycle t+1.

## Timing
- Reset (async, rst_n low):
  - head = tail = count = 0.
  - read_valid_o = 0, count_o = 0.
  - write_ready_o = ~hold_i.
  - Storage is not reset.
- Write-to-read latency: 1 cycle.
- Outputs are combinational from registers, plus hold_i for write_ready_o. No input-to-output combinational path exists except hold_i→write_ready_o.
- Full boundary: write_ready_o drops once count > DEPTH − FETCH_WIDTH, even if a pop occurs that cycle.
- Empty boundary: read_valid_o = 0 and pops are no-ops.
- Wrap: pointer arithmetic modulo DEPTH. Multi-entry writes and reads spanning index DEPTH−1→0 are contiguous in logical order.
- Reset deasserting mid-stream: the queue restarts empty. No stale entry becomes valid.

## Test plan
Defaults throughout (FETCH_WIDTH=2, ISSUE_WIDTH=2, DEPTH=8).

- **Compaction:** write mask 2'b10, lane1=A, then mask 2'b11 (B,C), read_ready_i=0 → count_o=3; read_data_o lanes = A,B; read_valid_o=2'b11.
- **Fill/backpressure:** write 4 full groups with no reads → count_o=8, write_ready_o=0.
  - Next cycle pop 2 with write_valid_i high → write not accepted, count_o=6.
  - Cycle after → write_ready_o=1.
- **Wrap-around:** preload head=tail=7 via 7 single writes and 7 pops. Write (X,Y) → entries at 7 and 0. Read 2 → X then Y; count_o returns to 0.
- **Simultaneous read/write:** count=3 (A,B,C). Write (D,E) and pop 2 in the same cycle → count_o=3; head lanes = C,D.
- **Flush priority:** count=5, assert flush_i together with a write and a pop → next cycle count_o=0, read_valid_o=0. Subsequent write F → read_data_o lane0=F one cycle later.
- **Idle hold and reset:**
  - hold_i=1 with count=4 → write_ready_o=0; 2 pops still drain to count_o=2.
  - Assert rst_n low asynchronously mid-operation → count_o=0 and read_valid_o=0 immediately, without waiting for a clock edge.
